pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. Sits beside the decoder and drives the enable/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from hazard information in ID and EX, a taken-branch indication from EX and the data-memory handshake in MEM. It resolves load-use stalls, branch/jump flushes and multi-cycle memory waits, and includes a memory-timeout trap.

## Interface
- MEM_TIMEOUT, 16: data-memory wait cycles tolerated before the error trap; 1..65535.
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_jump  in  1  j/jal/jr in ID; target is resolved in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_branch_taken  in  1  beq/bne in EX resolved taken.
- mem_req  in  1  MEM stage performs a data-memory read or write.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register update enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (all controls 0) into IF/ID or ID/EX.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  32  perf counter; see Configuration.
- flush_events  out  32  perf counter; see Configuration.

## Operation
- FSM states are RUN, MWAIT and MERR. Reset enters RUN.
- Enables/flushes are combinational from the current state and inputs, using the priority below (highest first):
  1. rst=1: all enables 0, ifid_flush=idex_flush=1.
  2. MERR: all enables 0, no flushes. The pipeline is frozen.
  3. Memory freeze: (RUN or MWAIT) and mem_req=1 and mem_ready=0. All enables 0, no flushes. The freeze overrides any branch, load-use or jump request; those requests remain pending because the pipeline registers hold them.
  4. ex_branch_taken=1: all enables 1, ifid_flush=1, idex_flush=1. Load-use and jump are ignored because their instructions are squashed.
  5. Load-use: ex_memread=1, ex_rt≠0, and (id_uses_rs & id_rs==ex_rt or id_uses_rt & id_rt==ex_rt). pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  6. id_jump=1 (no load-use): all enables 1, ifid_flush=1.
  7. Otherwise all enables 1 and no flushes.
- Register $0 never causes a load-use stall.
- FSM transitions:
  - RUN→MWAIT when a memory freeze occurs. The wait counter is set to 1.
  - In MWAIT, mem_ready=1 returns to RUN. The pipeline advances in that same cycle with normal priority, and the counter clears.
  - In MWAIT, if the counter equals MEM_TIMEOUT with mem_ready=0, go to MERR and set mem_err=1. Otherwise the counter increments. The counter is 16 bits.
  - MERR is left only by rst.
- mem_req=1 with mem_ready=1 in RUN causes no freeze and no state change.

## Timing
- Reset values: state RUN, wait counter 0, mem_err 0, stall_cycles 0, flush_events 0. Outputs during rst follow priority 1.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and no hazard remains.
- A taken branch costs 2 bubbles and a jump costs 1 bubble. Both take effect in the same cycle the condition is seen.
- A memory access with ready at cycle k after mem_req: k frozen cycles. A single-cycle ready gives 0 frozen cycles.
- Timeout: mem_err rises on the edge after MEM_TIMEOUT+1 consecutive not-ready cycles (MWAIT entry plus MEM_TIMEOUT cycles in MWAIT).
- rst asserted in MWAIT or MERR clears the state on the next edge. A pending access is discarded.

## Configuration
- PIPE_PERF_CNT_EN defined: performance counters are compiled in.
  - stall_cycles increments on every cycle with pc_en=0 while not in rst, including MERR.
  - flush_events increments on every cycle with ifid_flush=1 while not in rst.
  - Both counters wrap modulo 2^32.
- PIPE_PERF_CNT_EN undefined: both ports are constant 0 and no counter flops exist.

## Test plan
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle (ex_memread=0) all enables are 1.
- $0 and non-use: ex_rt=0 with id_rs=0, or ex_rt=8 with id_uses_rs=id_uses_rt=0 → no stall.
- Branch vs load-use vs jump: ex_branch_taken=1 together with a load-use match and id_jump=1 → all enables 1, ifid_flush=idex_flush=1. With ex_branch_taken=0 and id_jump=1 only → only ifid_flush=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high → 3 frozen cycles, the branch held in EX flushes on the ready cycle, state returns to RUN, and stall_cycles=3 (macro defined).
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_err=1 after 5 frozen cycles. Asserting mem_ready afterwards stays frozen. A 1-cycle rst clears to RUN with mem_err=0.
- Macro off: the same load-use stimulus gives stall_cycles=0 and flush_events=0, with identical control outputs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use stalls, branch/jump flushes,
// memory wait freezes and a memory-timeout trap. Optional perf counters behind PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_jump,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        load_use;
  logic        mem_freeze;

  always_comb begin
    load_use   = ex_memread && (ex_rt != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    mem_freeze = (state_q != MERR) && mem_req && !mem_ready;
  end

  // Pipeline controls by priority; a freeze holds branch/load-use/jump requests in place.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state_q == MERR) || mem_freeze) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_freeze) begin
          state_d    = MWAIT;
          wait_cnt_d = 16'd1;
        end
      end
      MWAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
          state_d   = MERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      MERR: begin
        state_d = MERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Counts include the MERR freeze; reset cycles are excluded by the synchronous clear.
  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(!pc_en);
    flush_events_d = flush_events_q + 32'(ifid_flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a behavioural model that tracks
// consecutive unfinished memory cycles, the sticky error and the perf counts.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, id_jump, ex_memread, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic        mem_err;
  logic [31:0] stall_cycles, flush_events;

  int          checks = 0;
  int          errors = 0;

  int          busy = 0;
  bit          errored = 1'b0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational and registered outputs, advance the model.
  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic jmp,
                               input logic mrd, input logic [4:0] ert, input logic bt,
                               input logic mreq, input logic mrdy);
    logic [6:0] exp_ctrl;
    bit         hazard;
    bit         frozen;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_jump = jmp;
    ex_memread = mrd; ex_rt = ert; ex_branch_taken = bt; mem_req = mreq; mem_ready = mrdy;
    #1;
    hazard = mrd && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));
    frozen = mreq && !mrdy;
    // bit order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
    if (r)                    exp_ctrl = 7'b00000_11;
    else if (errored)         exp_ctrl = 7'b00000_00;
    else if (frozen)          exp_ctrl = 7'b00000_00;
    else if (bt)              exp_ctrl = 7'b11111_11;
    else if (hazard)          exp_ctrl = 7'b00111_01;
    else if (jmp)             exp_ctrl = 7'b11111_10;
    else                      exp_ctrl = 7'b11111_00;
    checkOutput("ctrl", {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
                {25'd0, exp_ctrl});
    checkOutput("mem_err", {31'd0, mem_err}, {31'd0, errored});
    checkOutput("stall_cycles", stall_cycles, PERF ? exp_stall : 32'd0);
    checkOutput("flush_events", flush_events, PERF ? exp_flush : 32'd0);
    @(posedge clk);
    if (r) begin
      busy = 0; errored = 1'b0; exp_stall = 32'd0; exp_flush = 32'd0;
    end else begin
      exp_stall += {31'd0, !exp_ctrl[6]};
      exp_flush += {31'd0, exp_ctrl[1]};
      if (!errored) begin
        if (frozen) begin
          busy++;
          if (busy > int'(TIMEOUT)) errored = 1'b1;
        end else begin
          busy = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulseReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    pulseReset();
    pulseReset();
    idle();

    // load-use on rs, then load leaves EX
    applyStimulus(0, 8, 3, 1, 0, 0, 1, 8, 0, 0, 1);
    applyStimulus(0, 8, 3, 1, 0, 0, 0, 8, 0, 0, 1);
    // load-use via rt
    applyStimulus(0, 2, 9, 0, 1, 0, 1, 9, 0, 0, 0);
    // $0 and unused operands never stall
    applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 8, 8, 0, 0, 0, 1, 8, 0, 0, 0);
    // branch beats load-use and jump; then jump alone
    applyStimulus(0, 8, 0, 1, 0, 1, 1, 8, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // 3-cycle memory wait with a taken branch held in EX
    pulseReset();
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("wait_stall", stall_cycles, PERF ? 32'd3 : 32'd0);
    checkOutput("wait_flush", flush_events, PERF ? 32'd1 : 32'd0);
    idle();

    // timeout trap, stays frozen after ready, cleared by reset
    pulseReset();
    repeat (TIMEOUT + 1) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("timeout_err", {31'd0, mem_err}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    pulseReset();
    idle();
    checkOutput("reset_clears_err", {31'd0, mem_err}, 32'd0);

    // randomized traffic; ready probability varies by phase to reach the timeout sometimes
    for (int i = 0; i < 3000; i++) begin
      logic r, mreq, mrdy;
      r    = ($urandom_range(0, 99) < 2);
      mreq = ($urandom_range(0, 2) == 0);
      if (busy > 0 && !errored) mreq = 1'b1;
      mrdy = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      applyStimulus(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                    1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                    mreq, mrdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
